// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master to one-slave Wishbone classic arbiter.
//
// Master 0 (CPU) and master 1 (DMA/debug loader) share one slave bus.
// Arbitration is round-robin. A grant is held for as long as the granted
// master keeps cyc high, so multi-beat and read-modify-write sequences
// see a locked bus.
//
// Handshake: a master requests the bus by raising mX_cyc_i. Once it is
// granted, its cyc/stb/we/adr/sel/dat pass combinationally to the slave.
// A beat completes on a clock edge where the slave's ack/err/rty is high.
// Each response is returned only to the granted master, and only while
// that master holds cyc and stb. Read data (dat_i) is broadcast to both
// masters and is meaningful only while the matching ack is high.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   mX_cyc_i/stb_i/we_i       master X request signals (X = 0, 1)
//   mX_adr_i/sel_i/dat_i      master X address, byte select and write data
//   mX_dat_o                  read data to master X
//   mX_ack_o/err_o/rty_o      responses to master X
//   cyc_o/stb_o/we_o          slave-side control
//   adr_o/sel_o/dat_o         slave address, byte select and write data
//   dat_i, ack_i/err_i/rty_i  slave read data and responses
//   grant_o                   one-hot current grant; 00 means IDLE
//
// Optional feature (macro WB_ARBITER_TIMEOUT_EN): a watchdog raises a
// one-cycle error to the granted master after TIMEOUT stalled cycles.
// When the macro is not defined, TIMEOUT is ignored.

module wb_arbiter_2m #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic                    m0_rty_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    m1_rty_o,
  output logic                    cyc_o,
  output logic                    stb_o,
  output logic                    we_o,
  output logic [ADDR_WIDTH-1:0]   adr_o,
  output logic [DATA_WIDTH/8-1:0] sel_o,
  output logic [DATA_WIDTH-1:0]   dat_o,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic                    ack_i,
  input  logic                    err_i,
  input  logic                    rty_i,
  output logic [1:0]              grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  // last_q records which master held the bus most recently. Its reset
  // value of 1 lets master 0 win the first tie.
  logic   last_q, last_d;
  logic   gnt0, gnt1;
  logic   to_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Release goes straight to the other master when it is already waiting,
  // so a handover costs no IDLE cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grants are also gated by rst_i, so the bus stays quiet for the whole
  // reset cycle, including the first edge, before state is known.
  assign gnt0 = (state_q == GNT0) && !rst_i;
  assign gnt1 = (state_q == GNT1) && !rst_i;

  always_comb begin
    cyc_o    = 1'b0;
    stb_o    = 1'b0;
    we_o     = 1'b0;
    adr_o    = '0;
    sel_o    = '0;
    dat_o    = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    m0_dat_o = '0;
    m1_dat_o = '0;
    grant_o  = {gnt1, gnt0};
    if (gnt0) begin
      cyc_o    = m0_cyc_i;
      stb_o    = m0_stb_i;
      we_o     = m0_we_i;
      adr_o    = m0_adr_i;
      sel_o    = m0_sel_i;
      dat_o    = m0_dat_i;
      // Responses are gated by the master's own cyc/stb. A late ack after
      // the master abandons a beat is therefore dropped.
      m0_ack_o = ack_i & m0_cyc_i & m0_stb_i & ~to_hit;
      m0_err_o = (err_i | to_hit) & m0_cyc_i & m0_stb_i;
      m0_rty_o = rty_i & m0_cyc_i & m0_stb_i & ~to_hit;
    end else if (gnt1) begin
      cyc_o    = m1_cyc_i;
      stb_o    = m1_stb_i;
      we_o     = m1_we_i;
      adr_o    = m1_adr_i;
      sel_o    = m1_sel_i;
      dat_o    = m1_dat_i;
      m1_ack_o = ack_i & m1_cyc_i & m1_stb_i & ~to_hit;
      m1_err_o = (err_i | to_hit) & m1_cyc_i & m1_stb_i;
      m1_rty_o = rty_i & m1_cyc_i & m1_stb_i & ~to_hit;
    end
    if (gnt0 || gnt1) begin
      m0_dat_o = dat_i;
      m1_dat_o = dat_i;
    end
  end

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  logic [CW-1:0] to_cnt_q;

  // The count restarts whenever the slave answers or the bus changes
  // owner. It holds while stb is low between beats.
  assign to_hit = (to_cnt_q == TO_VAL) && cyc_o && stb_o;

  always_ff @(posedge clk_i) begin
    if (rst_i || state_q == IDLE || state_d != state_q ||
        ack_i || err_i || rty_i || to_hit) begin
      to_cnt_q <= '0;
    end else if (cyc_o && stb_o) begin
      to_cnt_q <= to_cnt_q + CW'(1);
    end
  end
`else
  assign to_hit = 1'b0;
`endif

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
Two-master to one-slave Wishbone classic arbiter. It shares the single slave bus (memory_infer, flash and the address decoder) between the CPU (master 0) and a second master (master 1: DMA/debug loader).
- Round-robin grant; a grant is held for the whole cyc burst.
- Slave responses are routed only to the granted master.

Parameters:
- ADDR_WIDTH, 32, width of adr signals
- DATA_WIDTH, 32, width of dat signals; sel width = DATA_WIDTH/8
- TIMEOUT, 255, cycles without a slave response before a forced error (only used with the optional feature)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 bus request signals
- m0_adr_i  in  ADDR_WIDTH  master 0 address
- m0_sel_i  in  DATA_WIDTH/8  master 0 byte select
- m0_dat_i  in  DATA_WIDTH  master 0 write data
- m0_dat_o  out  DATA_WIDTH  read data to master 0
- m0_ack_o, m0_err_o, m0_rty_o  out  1 each  responses to master 0
- m1_*  (same set as m0_*)  master 1
- cyc_o, stb_o, we_o  out  1 each  slave-side control
- adr_o  out  ADDR_WIDTH  slave address
- sel_o  out  DATA_WIDTH/8  slave byte select
- dat_o  out  DATA_WIDTH  slave write data
- dat_i  in  DATA_WIDTH  slave read data
- ack_i, err_i, rty_i  in  1 each  slave responses
- grant_o  out  2  one-hot current grant (debug/observability)

Behaviour:
- Registered FSM with states IDLE, GNT0, GNT1, plus a last_grant flag.
- Reset values: state=IDLE, last_grant=1 (so master 0 wins the first tie).
- While in IDLE or under reset, all outputs are 0: cyc_o, stb_o, we_o, adr_o, sel_o, dat_o, every m*_ack/err/rty, grant_o.
- IDLE transitions:
  - only m0_cyc_i -> GNT0
  - only m1_cyc_i -> GNT1
  - both -> the master != last_grant
- Arbitration latency: 1 clock from cyc_i rising in IDLE to cyc_o asserting.
- GNTx:
  - Slave outputs are driven combinationally from master x: cyc, stb, we, adr, sel, dat.
  - ack_o/err_o/rty_o of master x = the matching slave response AND mx_cyc_i AND mx_stb_i.
  - The non-granted master sees all responses at 0.
  - m0_dat_o = m1_dat_i-side read data = dat_i, broadcast to both masters; it is qualified only by ack.
- Grant hold: the FSM stays in GNTx while mx_cyc_i=1, regardless of the other master or of stb toggling. This gives bus-lock semantics for read-modify-write sequences.
- Release when mx_cyc_i=0 at a clock edge:
  - set last_grant=x
  - if the other master's cyc_i=1, go directly to GNT(other) with no IDLE bubble
  - otherwise go to IDLE
- Simultaneous drop of cyc by the granted master and rise by the other: handover on the same edge, as above.
- A master dropping cyc mid-transfer (before ack) is legal. Slave cyc_o falls combinationally, the grant releases at the next edge, and a late ack is not routed (gated by cyc).
- Reset mid-transaction: the edge with rst_i=1 forces IDLE. Slave-side cyc_o is low from that edge on, and no response reaches any master.
- No combinational path from ack_i to any m*_cyc/stb; the slave side must not loop back.

Optional Feature:
- Macro: WB_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) increments each cycle with cyc_o&stb_o=1 and ack_i|err_i|rty_i=0.
  - It clears on any response, on a grant change, in IDLE, and on reset.
  - When count==TIMEOUT, the granted master gets a single-cycle err_o=1 (ack_o=0) and the counter clears.
  - Further stalls repeat every TIMEOUT+1 cycles.
- Undefined: no counter; the TIMEOUT parameter is ignored; a stalled slave hangs the bus indefinitely.

Test Plan:
1. After reset, m0 reads 0x2000_0000 (mem word 0x1234_5678) alone.
   -> cyc_o rises 1 clock after m0_cyc_i; adr_o=0x2000_0000; m0_ack_o pulses with m0_dat_o=0x1234_5678; m1_ack_o stays 0.
2. m0 and m1 raise cyc on the same edge after reset.
   -> grant_o=01 first; on m0 cyc drop, grant_o=10 on the same edge with no IDLE cycle; m1 write of 0xCAFE_F00D lands in mem[1].
3. Repeated simultaneous requests (4 rounds).
   -> grants alternate 01,10,01,10.
4. m1 holds cyc across two stb beats (read mem[0], then write mem[0]=0xDEAD_BEEF with sel=0011) while m0 requests.
   -> m0 is not granted until m1 cyc falls; mem[0] low half is updated, high half unchanged.
5. rst_i asserted for 1 cycle while m0 is awaiting ack.
   -> cyc_o=0 from the next edge; grant_o=00; m0_ack_o never asserts.
6. With WB_ARBITER_TIMEOUT_EN and TIMEOUT=8, the slave never acks.
   -> m0_err_o=1 for exactly one cycle, 8 cycles after stb_o rose; m0_ack_o=0 throughout.
